// File: rtl/pmem_loader_if.sv
// Byte-stream and program-memory write bus between the swt16 program loader and its environment.
// master drives the byte stream and watches the write port; slave is the loader.
interface pmem_loader_if #(
    parameter int PMEM_ADDR_WIDTH = 12,
    parameter int PMEM_WORD_WIDTH = 16
);
    logic [7:0]                 byte_data;
    logic                       valid;
    logic                       ready;
    logic                       pmem_we;
    logic [PMEM_ADDR_WIDTH-1:0] pmem_addr;
    logic [PMEM_WORD_WIDTH-1:0] pmem_word;
    logic                       cpu_hold;
    logic                       done;
    logic                       error;

    modport master (
        output byte_data, valid,
        input  ready, pmem_we, pmem_addr, pmem_word, cpu_hold, done, error
    );

    modport slave (
        input  byte_data, valid,
        output ready, pmem_we, pmem_addr, pmem_word, cpu_hold, done, error
    );
endinterface

// File: rtl/pmem_loader.sv
// pmem_loader: assembles a framed byte stream into 16-bit words and writes them to swt16 program memory.
// Define PMEM_LOADER_CHECKSUM_EN to require a trailing modulo-256 checksum byte per frame.
module pmem_loader #(
    parameter int         PMEM_ADDR_WIDTH = 12,
    parameter int         PMEM_WORD_WIDTH = 16,
    parameter int         PC_INCREMENT    = 2,
    parameter logic [7:0] SYNC_BYTE       = 8'hA5
) (
    input  logic         clock,
    input  logic         reset,
    pmem_loader_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI,
        DATA_LO, DATA_HI, WRITE, CHECK, FINISH
    } state_t;

    state_t                     state;
    logic                       ready_q;
    logic                       we_q;
    logic [PMEM_ADDR_WIDTH-1:0] pmem_addr_q;
    logic [PMEM_WORD_WIDTH-1:0] word_q;
    logic                       hold_q;
    logic                       done_q;
    logic [PMEM_ADDR_WIDTH-1:0] addr_q;
    logic [6:0]                 addr_lo_q;
    logic [7:0]                 cnt_lo_q;
    logic [15:0]                remaining_q;
    logic [7:0]                 lo_q;
`ifdef PMEM_LOADER_CHECKSUM_EN
    logic [7:0]                 chk_q;
    logic                       error_q;
`endif

    logic accept;
    assign accept = bus.valid && ready_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the datapath registers are reset too, so the write port never shows X after reset.
            state       <= IDLE;
            ready_q     <= 1'b1;
            we_q        <= 1'b0;
            pmem_addr_q <= '0;
            word_q      <= '0;
            hold_q      <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= '0;
            addr_lo_q   <= '0;
            cnt_lo_q    <= '0;
            remaining_q <= '0;
            lo_q        <= '0;
`ifdef PMEM_LOADER_CHECKSUM_EN
            chk_q       <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            // NOTE: pulse outputs default low each cycle; the case below raises them for exactly one cycle.
            we_q   <= 1'b0;
            done_q <= 1'b0;
`ifdef PMEM_LOADER_CHECKSUM_EN
            error_q <= 1'b0;
            if (accept && (state inside {ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, DATA_LO, DATA_HI}))
                chk_q <= chk_q + bus.byte_data;
`endif
            case (state)
                IDLE: begin
                    if (accept && bus.byte_data == SYNC_BYTE) begin
                        state  <= ADDR_LO;
                        hold_q <= 1'b1;
`ifdef PMEM_LOADER_CHECKSUM_EN
                        chk_q  <= '0;
`endif
                    end
                end
                ADDR_LO: begin
                    if (accept) begin
                        addr_lo_q <= bus.byte_data[7:1];
                        state     <= ADDR_HI;
                    end
                end
                ADDR_HI: begin
                    if (accept) begin
                        // Word-aligned: bit 0 is dropped, upper bits beyond the memory size are truncated.
                        addr_q <= PMEM_ADDR_WIDTH'({bus.byte_data, addr_lo_q, 1'b0});
                        state  <= CNT_LO;
                    end
                end
                CNT_LO: begin
                    if (accept) begin
                        cnt_lo_q <= bus.byte_data;
                        state    <= CNT_HI;
                    end
                end
                CNT_HI: begin
                    if (accept) begin
                        remaining_q <= {bus.byte_data, cnt_lo_q};
                        if ({bus.byte_data, cnt_lo_q} == 16'd0) begin
`ifdef PMEM_LOADER_CHECKSUM_EN
                            state   <= CHECK;
`else
                            state   <= FINISH;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
`endif
                        end else begin
                            state <= DATA_LO;
                        end
                    end
                end
                DATA_LO: begin
                    if (accept) begin
                        lo_q  <= bus.byte_data;
                        state <= DATA_HI;
                    end
                end
                DATA_HI: begin
                    if (accept) begin
                        word_q      <= {bus.byte_data, lo_q};
                        pmem_addr_q <= addr_q;
                        we_q        <= 1'b1;
                        ready_q     <= 1'b0;
                        state       <= WRITE;
                    end
                end
                WRITE: begin
                    addr_q      <= addr_q + PMEM_ADDR_WIDTH'(PC_INCREMENT);
                    remaining_q <= remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
`ifdef PMEM_LOADER_CHECKSUM_EN
                        state   <= CHECK;
                        ready_q <= 1'b1;
`else
                        state   <= FINISH;
                        done_q  <= 1'b1;
`endif
                    end else begin
                        state   <= DATA_LO;
                        ready_q <= 1'b1;
                    end
                end
`ifdef PMEM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (accept) begin
                        done_q  <= (bus.byte_data == chk_q);
                        error_q <= (bus.byte_data != chk_q);
                        ready_q <= 1'b0;
                        state   <= FINISH;
                    end
                end
`endif
                FINISH: begin
                    hold_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    hold_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.pmem_we   = we_q;
    assign bus.pmem_addr = pmem_addr_q;
    assign bus.pmem_word = word_q;
    assign bus.cpu_hold  = hold_q;
    assign bus.done      = done_q;
`ifdef PMEM_LOADER_CHECKSUM_EN
    assign bus.error     = error_q;
`else
    assign bus.error     = 1'b0;
`endif
endmodule
